// File: rtl/vote_pkg.sv
// Shared definitions for the ballot-collection front end: voter count,
// FSM state encoding, default threshold and a 4-bit popcount helper.
package vote_pkg;

    localparam int N_VOTERS   = 4;
    localparam int THRESH_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_TALLY = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [2:0] popcount4(input logic [N_VOTERS-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < N_VOTERS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_tally.sv
// Combinational tally: counts yes ballots among cast stations and compares
// the count against the threshold. Registered by the caller.
module vote_tally
    import vote_pkg::*;
#(
    parameter int THRESH = THRESH_DEF
) (
    input  logic [N_VOTERS-1:0] masked_ballot,
    output logic [2:0]          yes_cnt,
    output logic                result
);

    // Popcount and threshold compare.
    always_comb begin
        yes_cnt = popcount4(masked_ballot);
        result  = (yes_cnt >= 3'(THRESH));
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session controller: opens a timed window on start, collects one
// ballot per station through a valid/ack handshake, then tallies and
// publishes a registered result with a one-cycle done pulse.
// Optional feature macro: VOTE_REVOTE_EN (stations may re-vote while OPEN;
// the session then closes only on window expiry).
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  ST_IDLE  | waiting for start, last result held
//  ST_OPEN  | window running, ballots accepted
//  ST_TALLY | one cycle, yes count and result registered
//  ST_DONE  | one cycle, done pulse, then back to idle
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int WIN_CYCLES = 1000,
    parameter int CNT_W      = 16,
    parameter int THRESH     = THRESH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_val,
    output logic [N_VOTERS-1:0] vote_ack,
    output logic                busy,
    output logic                done,
    output logic                result,
    output logic [2:0]          yes_cnt,
    output logic [2:0]          cast_cnt,
    output logic                timed_out
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [N_VOTERS-1:0] cast;
    logic [N_VOTERS-1:0] ballot;

    logic [N_VOTERS-1:0] accept;
    logic [N_VOTERS-1:0] cast_nxt;
    logic [N_VOTERS-1:0] ballot_nxt;
    logic                win_last;
    logic                close;
    logic [2:0]          tally_yes;
    logic                tally_res;

    // Acceptance and close decision for the current OPEN cycle.
    always_comb begin
        win_last = (cnt == CNT_W'(WIN_CYCLES - 1));
`ifdef VOTE_REVOTE_EN
        accept   = vote_valid;
        cast_nxt = cast | accept;
        close    = win_last;
`else
        accept   = vote_valid & ~cast;
        cast_nxt = cast | accept;
        close    = win_last | (&cast_nxt);
`endif
        ballot_nxt = (ballot & ~accept) | (vote_val & accept);
    end

    vote_tally #(.THRESH(THRESH)) u_tally (
        .masked_ballot (cast & ballot),
        .yes_cnt       (tally_yes),
        .result        (tally_res)
    );

    // Session FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cast      <= '0;
            ballot    <= '0;
            vote_ack  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 1'b0;
            yes_cnt   <= 3'd0;
            cast_cnt  <= 3'd0;
            timed_out <= 1'b0;
        end else begin
            vote_ack <= '0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_OPEN;
                        cnt       <= '0;
                        cast      <= '0;
                        ballot    <= '0;
                        cast_cnt  <= 3'd0;
                        yes_cnt   <= 3'd0;
                        result    <= 1'b0;
                        timed_out <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                ST_OPEN: begin
                    cast     <= cast_nxt;
                    ballot   <= ballot_nxt;
                    vote_ack <= accept;
                    cast_cnt <= popcount4(cast_nxt);
                    if (close) begin
                        state     <= ST_TALLY;
                        timed_out <= (cast_nxt != {N_VOTERS{1'b1}});
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_TALLY: begin
                    yes_cnt <= tally_yes;
                    result  <= tally_res;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state   <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
